// File: rtl/mips_pkg.sv
// Shared definitions for the multi-cycle MIPS subset core: widths, PC-source
// encodings shared with the decoder, and the fetch-stage state encoding.
package mips_pkg;

    localparam int unsigned WORD_W  = 32;
    localparam int unsigned JADDR_W = 26;
    localparam int unsigned PCSRC_W = 2;

    typedef logic [WORD_W-1:0]  word_t;
    typedef logic [PCSRC_W-1:0] pc_src_t;

    localparam pc_src_t PC_INC4 = 2'd0;
    localparam pc_src_t PC_J    = 2'd1;
    localparam pc_src_t PC_JR   = 2'd2;
    localparam pc_src_t PC_BNE  = 2'd3;

    typedef enum logic [1:0] {
        FS_RESET = 2'd0,
        FS_FETCH = 2'd1,
        FS_EXEC  = 2'd2,
        FS_FAULT = 2'd3
    } fetch_state_e;

    // Everything the PC sequencer needs from decode/execute for the held instruction
    typedef struct packed {
        pc_src_t              src;
        logic [JADDR_W-1:0]   jaddr;
        word_t                imm;
        logic                 bne;
        logic                 alu_zero;
        word_t                rs_data;
    } pc_ctrl_t;

    // BNE takes the branch on a nonzero compare, BEQ on a zero compare
    function automatic logic br_taken(input logic bne, input logic alu_zero);
        return bne ? !alu_zero : alu_zero;
    endfunction

endpackage

// File: rtl/next_pc.sv
// Combinational next-PC selection for the held instruction, plus the
// JR target misalignment flag.
module next_pc
    import mips_pkg::*;
(
    input  word_t    pc_plus4,
    input  pc_ctrl_t ctrl,
    output word_t    next_pc_c,
    output logic     jr_misaligned_c
);

    word_t branch_target;

    assign branch_target = pc_plus4 + {ctrl.imm[WORD_W-3:0], 2'b00};

    always_comb begin
        next_pc_c       = pc_plus4;
        jr_misaligned_c = 1'b0;
        case (ctrl.src)
            PC_INC4: next_pc_c = pc_plus4;
            PC_J:    next_pc_c = {pc_plus4[WORD_W-1:WORD_W-4], ctrl.jaddr, 2'b00};
            PC_JR: begin
                // Low bits are dropped rather than trapped; the flag reports it
                next_pc_c       = {ctrl.rs_data[WORD_W-1:2], 2'b00};
                jr_misaligned_c = |ctrl.rs_data[1:0];
            end
            PC_BNE:  next_pc_c = br_taken(ctrl.bne, ctrl.alu_zero) ? branch_target : pc_plus4;
            default: next_pc_c = pc_plus4;
        endcase
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch and PC sequencing: fetches over a req/valid handshake,
// holds the word for the decoder, and advances the PC when execute completes.
module fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned MAX_WAIT = 16
) (
    input  logic        clk,
    input  logic        rstN,
    output logic        imReq,
    output logic [31:0] imAddr,
    input  logic [31:0] imRdata,
    input  logic        imValid,
    output logic [31:0] instr,
    output logic        instrValid,
    output logic [31:0] pc,
    output logic [31:0] pcPlus4,
    input  logic [1:0]  pcSrcCtrl,
    input  logic [25:0] jAddr,
    input  logic [31:0] imm,
    input  logic        bneCtrl,
    input  logic        aluZero,
    input  logic [31:0] rsData,
    input  logic        exStall,
    output logic        retired,
    output logic        jrMisaligned,
    output logic        fault
);

    localparam int unsigned WAIT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
    // Counter value in the FETCH cycle that would be the MAX_WAIT-th without a response
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((MAX_WAIT == 0) ? 32'd0 : MAX_WAIT - 1);
    localparam logic TIMEOUT_EN = (MAX_WAIT != 0);

    fetch_state_e      state;
    fetch_state_e      state_nxt;
    logic [WAIT_W-1:0] wait_cnt;
    logic              accept_c;
    logic              exit_c;
    logic              timeout_c;
    word_t             next_pc_c;
    logic              jr_mis_c;
    pc_ctrl_t          pc_ctrl;

    assign accept_c  = (state == FS_FETCH) && imValid;
    assign exit_c    = (state == FS_EXEC) && !exStall;
    assign timeout_c = TIMEOUT_EN && (state == FS_FETCH) && !imValid && (wait_cnt == WAIT_LAST);

    assign imAddr  = pc;
    assign pcPlus4 = pc + 32'd4;

    assign pc_ctrl.src      = pcSrcCtrl;
    assign pc_ctrl.jaddr    = jAddr;
    assign pc_ctrl.imm      = imm;
    assign pc_ctrl.bne      = bneCtrl;
    assign pc_ctrl.alu_zero = aluZero;
    assign pc_ctrl.rs_data  = rsData;

    next_pc u_next_pc (
        .pc_plus4        (pcPlus4),
        .ctrl            (pc_ctrl),
        .next_pc_c       (next_pc_c),
        .jr_misaligned_c (jr_mis_c)
    );

    // State register
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state <= FS_RESET;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; a response in the timeout cycle still wins
    always_comb begin
        state_nxt = state;
        case (state)
            FS_RESET: state_nxt = FS_FETCH;
            FS_FETCH: begin
                if (imValid) begin
                    state_nxt = FS_EXEC;
                end else if (timeout_c) begin
                    state_nxt = FS_FAULT;
                end
            end
            FS_EXEC: begin
                if (!exStall) begin
                    state_nxt = FS_FETCH;
                end
            end
            FS_FAULT: state_nxt = FS_FAULT;
            default:  state_nxt = FS_RESET;
        endcase
    end

    // Output decode
    always_comb begin
        imReq        = 1'b0;
        instrValid   = 1'b0;
        fault        = 1'b0;
        retired      = 1'b0;
        jrMisaligned = 1'b0;
        case (state)
            FS_FETCH: imReq = 1'b1;
            FS_EXEC: begin
                instrValid   = 1'b1;
                retired      = !exStall;
                jrMisaligned = !exStall && jr_mis_c;
            end
            FS_FAULT: fault = 1'b1;
            default: ;
        endcase
    end

    // Consecutive FETCH cycles without a response
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            wait_cnt <= '0;
        end else if (state == FS_FETCH) begin
            if (imValid) begin
                wait_cnt <= '0;
            end else begin
                wait_cnt <= wait_cnt + WAIT_W'(1);
            end
        end
    end

    // Instruction hold register; cleared to a NOP on entering FAULT
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            instr <= '0;
        end else if (accept_c) begin
            instr <= imRdata;
        end else if (state_nxt == FS_FAULT) begin
            instr <= '0;
        end
    end

    // Program counter advances only when the held instruction leaves EXEC
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            pc <= RESET_PC;
        end else if (exit_c) begin
            pc <= next_pc_c;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: sequencing, branches, jumps, stalls,
// fetch timeout and asynchronous reset.
module tb_fetch_unit;
    import mips_pkg::*;

    logic        clk;
    logic        rstN;
    logic        imReq;
    logic [31:0] imAddr;
    logic [31:0] imRdata;
    logic        imValid;
    logic [31:0] instr;
    logic        instrValid;
    logic [31:0] pc;
    logic [31:0] pcPlus4;
    logic [1:0]  pcSrcCtrl;
    logic [25:0] jAddr;
    logic [31:0] imm;
    logic        bneCtrl;
    logic        aluZero;
    logic [31:0] rsData;
    logic        exStall;
    logic        retired;
    logic        jrMisaligned;
    logic        fault;

    int checks = 0;
    int errors = 0;

    logic [31:0] o_addr;
    logic [31:0] o_next;
    logic [31:0] o_instr;
    logic [31:0] o_pcp4;
    logic        o_ivalid;
    int          o_ret;
    int          o_mis;
    int          o_unstable;

    fetch_unit #(
        .RESET_PC (32'h0000_0040),
        .MAX_WAIT (4)
    ) dut (
        .clk          (clk),
        .rstN         (rstN),
        .imReq        (imReq),
        .imAddr       (imAddr),
        .imRdata      (imRdata),
        .imValid      (imValid),
        .instr        (instr),
        .instrValid   (instrValid),
        .pc           (pc),
        .pcPlus4      (pcPlus4),
        .pcSrcCtrl    (pcSrcCtrl),
        .jAddr        (jAddr),
        .imm          (imm),
        .bneCtrl      (bneCtrl),
        .aluZero      (aluZero),
        .rsData       (rsData),
        .exStall      (exStall),
        .retired      (retired),
        .jrMisaligned (jrMisaligned),
        .fault        (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Acts as memory and execute stage for one instruction; called at a negedge in FETCH
    task automatic run_instr(input logic [31:0] word, input int delay, input int stalls,
                             input logic [1:0] src, input logic [25:0] ja, input logic [31:0] im,
                             input logic bne, input logic az, input logic [31:0] rs);
        int n;
        o_ret = 0;
        o_mis = 0;
        o_unstable = 0;
        pcSrcCtrl = PC_INC4;
        exStall = 1'b0;
        imValid = 1'b0;
        n = 0;
        while (imReq !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (imReq !== 1'b1) begin
            errors++;
            $display("FAIL fetch_wait: imReq=%b required 1 within 20 cycles", imReq);
        end
        o_addr = imAddr;
        for (int i = 0; i < delay; i++) begin
            imValid = 1'b0;
            #1;
            if (retired === 1'b1) o_ret++;
            if (jrMisaligned === 1'b1) o_mis++;
            if (imReq !== 1'b1 || imAddr !== o_addr) o_unstable++;
            @(negedge clk);
        end
        imValid = 1'b1;
        imRdata = word;
        #1;
        if (retired === 1'b1) o_ret++;
        if (jrMisaligned === 1'b1) o_mis++;
        @(negedge clk);
        // Response strobes outside FETCH must be ignored
        imValid = 1'b1;
        imRdata = ~word;
        pcSrcCtrl = src;
        jAddr = ja;
        imm = im;
        bneCtrl = bne;
        aluZero = az;
        rsData = rs;
        o_instr = instr;
        o_ivalid = instrValid;
        o_pcp4 = pcPlus4;
        for (int i = 0; i < stalls; i++) begin
            exStall = 1'b1;
            #1;
            if (retired === 1'b1) o_ret++;
            if (jrMisaligned === 1'b1) o_mis++;
            @(negedge clk);
            if (instr !== o_instr || imAddr !== o_addr || instrValid !== 1'b1 || imReq !== 1'b0)
                o_unstable++;
        end
        exStall = 1'b0;
        #1;
        if (retired === 1'b1) o_ret++;
        if (jrMisaligned === 1'b1) o_mis++;
        @(negedge clk);
        imValid = 1'b0;
        pcSrcCtrl = PC_INC4;
        o_next = imAddr;
    endtask

    task automatic test_reset();
        rstN = 1'b0;
        imValid = 1'b1;
        imRdata = 32'hA5A5_A5A5;
        @(negedge clk);
        checks++;
        if (pc !== 32'h40) begin errors++; $display("FAIL reset_pc: got %h required 00000040", pc); end
        checks++;
        if (imReq !== 1'b0) begin errors++; $display("FAIL reset_imreq: got %b required 0", imReq); end
        checks++;
        if (instrValid !== 1'b0) begin errors++; $display("FAIL reset_ivalid: got %b required 0", instrValid); end
        checks++;
        if (instr !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h required 0", instr); end
        checks++;
        if (fault !== 1'b0 || retired !== 1'b0 || jrMisaligned !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: fault/retired/jrMis=%b%b%b required 000", fault, retired, jrMisaligned);
        end
        @(negedge clk);
        imValid = 1'b0;
        rstN = 1'b1;
        @(negedge clk);
        checks++;
        if (imReq !== 1'b1 || imAddr !== 32'h40) begin
            errors++;
            $display("FAIL reset_first_fetch: imReq=%b imAddr=%h required 1 00000040", imReq, imAddr);
        end
    endtask

    task automatic test_sequential();
        logic [31:0] words [3];
        logic [31:0] addrs [3];
        words[0] = 32'h2008_0001; words[1] = 32'h2109_0002; words[2] = 32'h214A_0003;
        addrs[0] = 32'h40;        addrs[1] = 32'h44;        addrs[2] = 32'h48;
        for (int k = 0; k < 3; k++) begin
            run_instr(words[k], 0, 0, PC_INC4, 26'h0, 32'h0, 1'b0, 1'b0, 32'h0);
            checks++;
            if (o_addr !== addrs[k]) begin
                errors++;
                $display("FAIL seq_addr%0d: got %h required %h", k, o_addr, addrs[k]);
            end
            checks++;
            if (o_instr !== words[k] || o_ivalid !== 1'b1) begin
                errors++;
                $display("FAIL seq_instr%0d: got %h/%b required %h/1", k, o_instr, o_ivalid, words[k]);
            end
            checks++;
            if (o_ret !== 1) begin
                errors++;
                $display("FAIL seq_retired%0d: got %0d pulses required 1", k, o_ret);
            end
        end
        checks++;
        if (o_pcp4 !== 32'h4C) begin errors++; $display("FAIL seq_pcplus4: got %h required 0000004c", o_pcp4); end
        checks++;
        if (o_next !== 32'h4C) begin errors++; $display("FAIL seq_next: got %h required 0000004c", o_next); end
    endtask

    task automatic test_branch();
        run_instr(32'h0100_0008, 0, 0, PC_JR, 26'h0, 32'h0, 1'b0, 1'b0, 32'h100);
        checks++;
        if (o_next !== 32'h100) begin errors++; $display("FAIL jr_setup: got %h required 00000100", o_next); end
        run_instr(32'h1509_FFFE, 0, 0, PC_BNE, 26'h0, 32'hFFFF_FFFE, 1'b1, 1'b0, 32'h0);
        checks++;
        if (o_next !== 32'h0FC) begin errors++; $display("FAIL bne_taken: got %h required 000000fc", o_next); end
        run_instr(32'h0100_0008, 0, 0, PC_JR, 26'h0, 32'h0, 1'b0, 1'b0, 32'h100);
        run_instr(32'h1509_FFFE, 0, 0, PC_BNE, 26'h0, 32'hFFFF_FFFE, 1'b1, 1'b1, 32'h0);
        checks++;
        if (o_next !== 32'h104) begin errors++; $display("FAIL bne_not_taken: got %h required 00000104", o_next); end
        run_instr(32'h1109_0004, 0, 0, PC_BNE, 26'h0, 32'h0000_0004, 1'b0, 1'b1, 32'h0);
        checks++;
        if (o_next !== 32'h118) begin errors++; $display("FAIL beq_taken: got %h required 00000118", o_next); end
        run_instr(32'h1109_0004, 0, 0, PC_BNE, 26'h0, 32'h0000_0004, 1'b0, 1'b0, 32'h0);
        checks++;
        if (o_next !== 32'h11C) begin errors++; $display("FAIL beq_not_taken: got %h required 0000011c", o_next); end
    endtask

    task automatic test_jump();
        run_instr(32'h0100_0008, 0, 0, PC_JR, 26'h0, 32'h0, 1'b0, 1'b0, 32'hF000_0010);
        checks++;
        if (o_next !== 32'hF000_0010 || o_mis !== 0) begin
            errors++;
            $display("FAIL jr_high: got %h mis=%0d required f0000010 mis=0", o_next, o_mis);
        end
        run_instr(32'h0800_0040, 0, 0, PC_J, 26'h000_0040, 32'h0, 1'b0, 1'b0, 32'h0);
        checks++;
        if (o_next !== 32'hF000_0100 || o_ret !== 1) begin
            errors++;
            $display("FAIL j_region: got %h ret=%0d required f0000100 ret=1", o_next, o_ret);
        end
        run_instr(32'h0100_0008, 0, 0, PC_JR, 26'h0, 32'h0, 1'b0, 1'b0, 32'h0000_0203);
        checks++;
        if (o_next !== 32'h200) begin errors++; $display("FAIL jr_misaligned_pc: got %h required 00000200", o_next); end
        checks++;
        if (o_mis !== 1) begin errors++; $display("FAIL jr_misaligned_pulse: got %0d pulses required 1", o_mis); end
        run_instr(32'h0100_0008, 0, 0, PC_JR, 26'h0, 32'h0, 1'b0, 1'b0, 32'hFFFF_FFFC);
        run_instr(32'h2008_0007, 0, 0, PC_INC4, 26'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        checks++;
        if (o_next !== 32'h0 || o_pcp4 !== 32'h0) begin
            errors++;
            $display("FAIL pc_wrap: next=%h pcPlus4=%h required 00000000 00000000", o_next, o_pcp4);
        end
    endtask

    task automatic test_stall();
        // Response in the 4th FETCH cycle also lands on the timeout boundary
        run_instr(32'h8C08_0010, 3, 2, PC_JR, 26'h0, 32'h0, 1'b0, 1'b0, 32'h0000_0301);
        checks++;
        if (o_unstable !== 0) begin errors++; $display("FAIL stall_stable: got %0d unstable cycles required 0", o_unstable); end
        checks++;
        if (o_addr !== 32'h0 || o_instr !== 32'h8C08_0010) begin
            errors++;
            $display("FAIL stall_fetch: addr=%h instr=%h required 00000000 8c080010", o_addr, o_instr);
        end
        checks++;
        if (o_ret !== 1 || o_mis !== 1) begin
            errors++;
            $display("FAIL stall_pulses: ret=%0d mis=%0d required 1 1", o_ret, o_mis);
        end
        checks++;
        if (o_next !== 32'h300 || fault !== 1'b0) begin
            errors++;
            $display("FAIL stall_next: next=%h fault=%b required 00000300 0", o_next, fault);
        end
    endtask

    task automatic test_reset_mid_exec();
        run_instr(32'h0100_0008, 0, 0, PC_JR, 26'h0, 32'h0, 1'b0, 1'b0, 32'h80);
        imValid = 1'b1;
        imRdata = 32'h2008_0009;
        @(negedge clk);
        exStall = 1'b1;
        imRdata = 32'hCAFE_F00D;
        checks++;
        if (pc !== 32'h80 || instrValid !== 1'b1) begin
            errors++;
            $display("FAIL mid_exec_setup: pc=%h ivalid=%b required 00000080 1", pc, instrValid);
        end
        #2;
        rstN = 1'b0;
        #1;
        checks++;
        if (pc !== 32'h40 || instrValid !== 1'b0 || instr !== 32'h0) begin
            errors++;
            $display("FAIL async_reset: pc=%h ivalid=%b instr=%h required 00000040 0 00000000", pc, instrValid, instr);
        end
        @(negedge clk);
        exStall = 1'b0;
        imValid = 1'b0;
        rstN = 1'b1;
        @(negedge clk);
        checks++;
        if (imReq !== 1'b1 || imAddr !== 32'h40 || instr !== 32'h0) begin
            errors++;
            $display("FAIL restart_fetch: imReq=%b imAddr=%h instr=%h required 1 00000040 00000000", imReq, imAddr, instr);
        end
    endtask

    task automatic test_timeout();
        run_instr(32'h2008_0005, 0, 0, PC_INC4, 26'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        imValid = 1'b0;
        for (int i = 0; i < 3; i++) @(negedge clk);
        checks++;
        if (fault !== 1'b0 || imReq !== 1'b1) begin
            errors++;
            $display("FAIL timeout_early: fault=%b imReq=%b after 3 cycles required 0 1", fault, imReq);
        end
        @(negedge clk);
        checks++;
        if (fault !== 1'b1 || imReq !== 1'b0 || instrValid !== 1'b0) begin
            errors++;
            $display("FAIL timeout_fault: fault=%b imReq=%b ivalid=%b required 1 0 0", fault, imReq, instrValid);
        end
        checks++;
        if (instr !== 32'h0) begin errors++; $display("FAIL timeout_instr: got %h required 00000000", instr); end
        imValid = 1'b1;
        imRdata = 32'h1234_5678;
        for (int i = 0; i < 3; i++) @(negedge clk);
        checks++;
        if (fault !== 1'b1 || instr !== 32'h0 || imAddr !== 32'h44) begin
            errors++;
            $display("FAIL fault_sticky: fault=%b instr=%h imAddr=%h required 1 00000000 00000044", fault, instr, imAddr);
        end
        rstN = 1'b0;
        #1;
        checks++;
        if (fault !== 1'b0) begin errors++; $display("FAIL fault_clear: got %b required 0", fault); end
        @(negedge clk);
        imValid = 1'b0;
        rstN = 1'b1;
        @(negedge clk);
        checks++;
        if (imReq !== 1'b1 || imAddr !== 32'h40) begin
            errors++;
            $display("FAIL fault_restart: imReq=%b imAddr=%h required 1 00000040", imReq, imAddr);
        end
    endtask

    initial begin
        rstN = 1'b0;
        imValid = 1'b0;
        imRdata = 32'h0;
        pcSrcCtrl = PC_INC4;
        jAddr = 26'h0;
        imm = 32'h0;
        bneCtrl = 1'b0;
        aluZero = 1'b0;
        rsData = 32'h0;
        exStall = 1'b0;
        test_reset();
        test_sequential();
        test_branch();
        test_jump();
        test_stall();
        test_reset_mid_exec();
        test_timeout();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
